// File: rtl/inc_dec_cnt_if.sv
// Control and status bundle for inc_dec_cnt: count controls in, count state out.
interface inc_dec_cnt_if #(
    parameter int unsigned SIZE = 4
);
    logic            CLR;
    logic            LD;
    logic [SIZE-1:0] D;
    logic            CE;
    logic            UP;
    logic            WRAP;
    logic [SIZE-1:0] Q;
    logic            TC;
    logic            CO;
    logic            OVF;

    modport master (
        output CLR, LD, D, CE, UP, WRAP,
        input  Q, TC, CO, OVF
    );

    modport slave (
        input  CLR, LD, D, CE, UP, WRAP,
        output Q, TC, CO, OVF
    );
endinterface

// File: rtl/inc_dec_cnt.sv
// Up/down counter with terminal value MAX_VAL, load clamp, wrap/saturate and a carry pulse.
// Optional sticky overflow flag enabled by defining INC_OVF_STICKY_EN.
module inc_dec_cnt #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned MAX_VAL = 9
) (
    input  logic         CLK,
    input  logic         R,
    inc_dec_cnt_if.slave bus
);
    localparam logic [SIZE-1:0] MAX_Q  = SIZE'(MAX_VAL);
    localparam logic [SIZE-1:0] ZERO_Q = '0;
    localparam logic [SIZE-1:0] ONE_Q  = SIZE'(1);

    logic [SIZE-1:0] q_q, q_d;
    logic            co_q, co_d;
    logic            at_top;
    logic            at_bot;

    assign at_top = (q_q == MAX_Q);
    assign at_bot = (q_q == ZERO_Q);

    // Priority CLR > LD > CE; Q never leaves [0, MAX_VAL] so q+1 / q-1 stay in SIZE bits.
    always_comb begin
        q_d  = q_q;
        co_d = 1'b0;
        if (bus.CLR) begin
            q_d = ZERO_Q;
        end else if (bus.LD) begin
            q_d = (bus.D > MAX_Q) ? MAX_Q : bus.D;
        end else if (bus.CE) begin
            if (bus.UP) begin
                if (!at_top) begin
                    q_d = q_q + ONE_Q;
                end else if (bus.WRAP) begin
                    q_d  = ZERO_Q;
                    co_d = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    q_d = q_q - ONE_Q;
                end else if (bus.WRAP) begin
                    q_d  = MAX_Q;
                    co_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            q_q  <= ZERO_Q;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            co_q <= co_d;
        end
    end

    assign bus.Q  = q_q;
    assign bus.CO = co_q;
    assign bus.TC = bus.UP ? at_top : at_bot;

`ifdef INC_OVF_STICKY_EN
    logic ovf_q, ovf_d;
    logic bound_evt;

    // A count attempted at the boundary is either a wrap or a blocked count.
    always_comb begin
        bound_evt = !bus.CLR && !bus.LD && bus.CE && (bus.UP ? at_top : at_bot);
        ovf_d     = ovf_q;
        if (bus.CLR) begin
            ovf_d = 1'b0;
        end else if (bound_evt) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.OVF = ovf_q;
`else
    assign bus.OVF = 1'b0;
`endif

endmodule
